// File: rtl/delay_sched.sv
// Delay scheduler: holds up to SLOTS payloads, each emitted once its
// requested delay has elapsed, lowest slot first, one event per cycle.
module delay_sched #(
   parameter int DATA_W = 32,
   parameter int DLY_W  = 8,
   parameter int SLOTS  = 4,
   localparam int CNT_W = $clog2(SLOTS + 1),
   localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_data,
   input  logic [DLY_W-1:0]  req_delay,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  pending,
   input  logic              flush
);

   logic [SLOTS-1:0]  active;
   logic [DATA_W-1:0] payload [SLOTS];
   logic [DLY_W-1:0]  count   [SLOTS];

   logic             free_found;
   logic [IDX_W-1:0] free_idx;
   logic             exp_found;
   logic [IDX_W-1:0] exp_idx;
   logic             load;

   // Descending scans so the lowest matching index wins.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      exp_found  = 1'b0;
      exp_idx    = '0;
      pending    = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!active[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (active[i] && count[i] == '0) begin
            exp_found = 1'b1;
            exp_idx   = IDX_W'(i);
         end
         pending = pending + CNT_W'(active[i]);
      end
   end

   assign req_ready = !rst && free_found;
   assign load      = req_valid && req_ready && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         active    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            payload[i] <= '0;
            count[i]   <= '0;
         end
      end else if (flush) begin
         active    <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= exp_found;
         if (exp_found) out_data <= payload[exp_idx];
         for (int i = 0; i < SLOTS; i++) begin
            if (exp_found && exp_idx == IDX_W'(i)) begin
               active[i] <= 1'b0;
            end else if (active[i] && count[i] != '0) begin
               count[i] <= count[i] - 1'b1;
            end
            // An issued slot is still active here, so it is never the free one.
            if (load && free_idx == IDX_W'(i)) begin
               active[i]  <= 1'b1;
               payload[i] <= req_data;
               count[i]   <= req_delay;
            end
         end
      end
   end

endmodule

// File: tb/tb_delay_sched.sv
// Bench for delay_sched: directed scenarios plus random traffic against
// a model that tracks each slot's absolute due cycle.
module tb_delay_sched;

   localparam int DW = 32;
   localparam int LW = 8;
   localparam int N  = 4;
   localparam int PW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [DW-1:0] req_data = '0;
   logic [LW-1:0] req_delay = '0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [PW-1:0] pending;
   logic          flush = 1'b0;

   delay_sched #(.DATA_W(DW), .DLY_W(LW), .SLOTS(N)) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_data(req_data),
      .req_delay(req_delay),
      .out_valid(out_valid),
      .out_data(out_data),
      .pending(pending),
      .flush(flush)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   bit            m_act  [N];
   logic [DW-1:0] m_data [N];
   longint        m_due  [N];
   bit            m_ov;
   logic [DW-1:0] m_od;
   longint        cyc;
   longint        acc_cyc;
   longint        first_out;
   int            pulses;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0h exp %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_act[i]  = 1'b0;
         m_data[i] = '0;
         m_due[i]  = 0;
      end
      m_ov = 1'b0;
      m_od = '0;
   endtask

   // Drive one cycle, compare outputs mid-cycle, then advance the model.
   task automatic step(input bit v, input logic [DW-1:0] d,
                       input logic [LW-1:0] dl, input bit f, input bit r);
      int     nfree;
      int     fr;
      int     iss;
      bit     rdy;
      req_valid = v;
      req_data  = d;
      req_delay = dl;
      flush     = f;
      rst       = r;
      @(negedge clk);
      nfree = 0;
      fr    = -1;
      iss   = -1;
      for (int i = N - 1; i >= 0; i--) begin
         if (!m_act[i]) begin
            nfree++;
            fr = i;
         end
         if (m_act[i] && m_due[i] <= cyc) iss = i;
      end
      rdy = !r && nfree > 0;
      check("req_ready", 64'(req_ready), 64'(rdy));
      check("pending", 64'(pending), 64'(N - nfree));
      check("out_valid", 64'(out_valid), 64'(m_ov));
      check("out_data", 64'(out_data), 64'(m_od));
      if (out_valid === 1'b1) begin
         pulses++;
         if (first_out < 0) first_out = cyc;
      end
      if (r) begin
         model_clear();
      end else if (f) begin
         for (int i = 0; i < N; i++) m_act[i] = 1'b0;
         m_ov = 1'b0;
      end else begin
         m_ov = (iss >= 0);
         if (iss >= 0) begin
            m_act[iss] = 1'b0;
            m_od       = m_data[iss];
         end
         if (v && fr >= 0) begin
            m_act[fr]  = 1'b1;
            m_data[fr] = d;
            m_due[fr]  = cyc + longint'(dl) + 1;
            acc_cyc    = cyc;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      cyc       = 0;
      acc_cyc   = 0;
      first_out = -1;
      pulses    = 0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      step(1'b0, '0, '0, 1'b1, 1'b1);
      step(1'b0, '0, '0, 1'b0, 1'b1);

      // Single event, delay 10
      pulses = 0;
      first_out = -1;
      step(1'b1, 32'hDEADBEEF, 8'd10, 1'b0, 1'b0);
      idle(14);
      check("lat_single", 64'(first_out - acc_cyc), 64'd12);
      check("pulses_single", 64'(pulses), 64'd1);

      // Back-to-back zero delay
      pulses = 0;
      first_out = -1;
      step(1'b1, 32'h0, 8'd0, 1'b0, 1'b0);
      check("lat_zero_accept", 64'(acc_cyc), 64'(cyc - 1));
      step(1'b1, 32'h1, 8'd0, 1'b0, 1'b0);
      step(1'b1, 32'h2, 8'd0, 1'b0, 1'b0);
      idle(4);
      check("pulses_zero", 64'(pulses), 64'd3);

      // Collision: two slots expire together
      step(1'b1, 32'hAAAA0001, 8'd2, 1'b0, 1'b0);
      step(1'b1, 32'hBBBB0002, 8'd1, 1'b0, 1'b0);
      idle(6);

      // Full, then req_valid held until accepted
      for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + i, 8'd20, 1'b0, 1'b0);
      for (int i = 0; i < 22; i++) step(1'b1, 32'h55, 8'd3, 1'b0, 1'b0);
      idle(30);

      // Flush with concurrent request
      for (int i = 0; i < 3; i++) step(1'b1, 32'h200 + i, 8'd15, 1'b0, 1'b0);
      idle(3);
      pulses = 0;
      step(1'b1, 32'hF00D, 8'd3, 1'b1, 1'b0);
      idle(25);
      check("pulses_flush", 64'(pulses), 64'd0);

      // Reset mid-run
      for (int i = 0; i < 2; i++) step(1'b1, 32'h300 + i, 8'd10, 1'b0, 1'b0);
      idle(4);
      pulses = 0;
      step(1'b0, '0, '0, 1'b0, 1'b1);
      idle(20);
      check("pulses_reset", 64'(pulses), 64'd0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 1) == 1,
              $urandom,
              LW'($urandom_range(0, 12)),
              $urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 1);
      end
      idle(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/delay_sched.md
DELAY_SCHED -- requirements
Module: delay_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of scheduled payload.
REQ-002 SHALL have parameter DLY_W, default 8, width of requested delay in cycles.
REQ-003 SHALL have parameter SLOTS, default 4, number of concurrently pending events (2..16).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  request to schedule payload.
REQ-007 SHALL have port req_ready  output  1  a free slot exists; handshake when req_valid && req_ready.
REQ-008 SHALL have port req_data  input  DATA_W  payload to emit after delay.
REQ-009 SHALL have port req_delay  input  DLY_W  delay in cycles, 0 allowed.
REQ-010 SHALL have port out_valid  output  1  registered one-cycle pulse per emitted event.
REQ-011 SHALL have port out_data  output  DATA_W  payload of emitted event, valid when out_valid.
REQ-012 SHALL have port pending  output  $clog2(SLOTS+1)  count of occupied slots.
REQ-013 SHALL have port flush  input  1  discard all pending events.

Function
REQ-014 Each slot SHALL hold: active bit, DATA_W payload, DLY_W countdown.
REQ-015 req_ready SHALL be combinational from current state only: high iff at least one slot inactive; independent of req_valid and of slots freeing this cycle.
REQ-016 On handshake, the lowest-index inactive slot SHALL load active=1, payload=req_data, countdown=req_delay.
REQ-017 Each edge, every active slot with countdown>0 SHALL decrement by 1; countdown SHALL never wrap below 0.
REQ-018 Active slot with countdown==0 is expired; expired slots SHALL hold state until issued.
REQ-019 Each edge, the lowest-index expired slot SHALL be issued: out_valid<=1, out_data<=its payload, slot active<=0.
REQ-020 With no expired slot, out_valid<=0; out_data SHALL hold its last value.
REQ-021 Latency without contention: handshake in cycle n -> out_valid in cycle n+req_delay+2 exactly.
REQ-022 Contention: at most one event per cycle; later-issued expired slots delayed one cycle each, in ascending index order.
REQ-023 A slot issued at an edge SHALL NOT be reloaded at that same edge; it becomes visible to req_ready the following cycle.
REQ-024 pending SHALL equal the number of active slots (registered state, no lookahead).
REQ-025 flush SHALL, at the edge, clear all active bits and force out_valid<=0; a handshake in the flush cycle SHALL be discarded.
REQ-026 No out_ready exists; emitted events SHALL never be back-pressured or lost.

Reset
REQ-027 rst SHALL clear all active bits, countdowns and payloads to 0; out_valid=0, out_data=0, pending=0.
REQ-028 While rst high, req_ready SHALL be 0 and handshakes ignored; rst has priority over flush.
REQ-029 rst mid-operation SHALL discard all pending events with no out_valid pulse in the cycle after reset deasserts unless a new request qualifies.

Verification
REQ-030 Single event: req_data=32'hDEADBEEF, req_delay=10 in cycle 5 -> out_valid single pulse in cycle 17, out_data=32'hDEADBEEF, pending 1 during cycles 6..16, then 0.
REQ-031 Zero delay: req_delay=0, req_data=32'h0 in cycle 3 -> out_valid in cycle 5; back-to-back delay-0 requests cycles 3,4,5 -> pulses cycles 5,6,7.
REQ-032 Collision: cycle 2 req (A, delay 2) to slot 0, cycle 3 req (B, delay 1) to slot 1 -> both expire together; A out in cycle 6, B in cycle 7.
REQ-033 Full: 4 requests delay 20 cycles 1..4 -> req_ready=0 cycles 5..22, pending=4; req_valid held high is accepted only after a slot frees, never dropped.
REQ-034 Flush: 3 pending events, flush in cycle 8 with concurrent req_valid -> pending=0 in cycle 9, no out_valid thereafter, new request not stored.
REQ-035 Reset mid-run: 2 pending events, rst high cycle 10 -> out_valid=0, pending=0, req_ready=0 in cycle 11; no stale event ever emitted.
